// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction-fetch stage wrapped around the program counter.
//
// Fetches the word at estado_pc from instruction memory over a req/ack
// handshake, holds it for decode behind a valid/ready handshake and computes
// the next PC (prox_instrucao), which the PC register loads on every edge.
//
// Ports:
//   clock, reset              - rising-edge clock, async active-low reset
//   estado_pc / prox_instrucao - current PC in, next PC out (combinational)
//   mem_req, mem_addr          - memory read request and word address
//   mem_ack, mem_dado          - memory read completion and returned word
//   desvio, desvio_alvo        - redirect from execute and its target
//   id_pronto                  - decode accepts the held instruction
//   if_valido, if_instrucao    - held instruction and its valid flag
//   if_pc, if_pc4              - address of held instruction and that + 4
module busca_instrucao #(
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] estado_pc,
    output logic [31:0] prox_instrucao,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_dado,
    input  logic        desvio,
    input  logic [31:0] desvio_alvo,
    input  logic        id_pronto,
    output logic        if_valido,
    output logic [31:0] if_instrucao,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    typedef enum logic [1:0] {
        Busca    = 2'd0,  // request outstanding
        Saida    = 2'd1,  // instruction held for decode
        Descarte = 2'd2   // stale request outstanding, data will be dropped
    } estado_e;

    estado_e     estado_q, estado_d;
    logic [31:0] instrucao_q, instrucao_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] end_pendente_q, end_pendente_d;
    logic [31:0] addr_sel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q       <= Busca;
            instrucao_q    <= NOP;
            pc_q           <= 32'd0;
            end_pendente_q <= 32'd0;
        end else begin
            estado_q       <= estado_d;
            instrucao_q    <= instrucao_d;
            pc_q           <= pc_d;
            end_pendente_q <= end_pendente_d;
        end
    end

    always_comb begin
        estado_d       = estado_q;
        instrucao_d    = instrucao_q;
        pc_d           = pc_q;
        end_pendente_d = end_pendente_q;
        prox_instrucao = estado_pc;
        mem_req        = 1'b0;
        addr_sel       = estado_pc;

        unique case (estado_q)
            Busca: begin
                mem_req = 1'b1;
                if (desvio) begin
                    prox_instrucao = desvio_alvo;
                    // Without the ack the request stays live on the bus; keep its
                    // address stable while the PC already moves to the target.
                    if (!mem_ack) begin
                        end_pendente_d = estado_pc;
                        estado_d       = Descarte;
                    end
                end else if (mem_ack) begin
                    instrucao_d    = mem_dado;
                    pc_d           = estado_pc;
                    prox_instrucao = estado_pc + 32'd4;
                    estado_d       = Saida;
                end
            end
            Saida: begin
                if (desvio) begin
                    instrucao_d    = NOP;
                    prox_instrucao = desvio_alvo;
                    estado_d       = Busca;
                end else if (id_pronto) begin
                    estado_d = Busca;
                end
            end
            Descarte: begin
                mem_req  = 1'b1;
                addr_sel = end_pendente_q;
                if (desvio) begin
                    prox_instrucao = desvio_alvo;
                end
                if (mem_ack) begin
                    estado_d = Busca;
                end
            end
            default: begin
                estado_d = Busca;
            end
        endcase

        // No request may be seen on the bus while the block is held in reset.
        if (!reset) begin
            mem_req = 1'b0;
        end
    end

    assign mem_addr     = {addr_sel[31:2], 2'b00};
    assign if_valido    = (estado_q == Saida);
    assign if_instrucao = instrucao_q;
    assign if_pc        = pc_q;
    assign if_pc4       = pc_q + 32'd4;

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock;
    logic        reset;
    logic [31:0] estado_pc;
    logic [31:0] prox_instrucao;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_dado;
    logic        desvio;
    logic [31:0] desvio_alvo;
    logic        id_pronto;
    logic        if_valido;
    logic [31:0] if_instrucao;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] pc_rst;

    busca_instrucao #(.NOP(NOP)) dut (
        .clock         (clock),
        .reset         (reset),
        .estado_pc     (estado_pc),
        .prox_instrucao(prox_instrucao),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_dado      (mem_dado),
        .desvio        (desvio),
        .desvio_alvo   (desvio_alvo),
        .id_pronto     (id_pronto),
        .if_valido     (if_valido),
        .if_instrucao  (if_instrucao),
        .if_pc         (if_pc),
        .if_pc4        (if_pc4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program counter register: loads prox_instrucao on every edge.
    always @(posedge clock or negedge reset) begin
        if (!reset) estado_pc <= pc_rst;
        else        estado_pc <= prox_instrucao;
    end

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h00500093;
        return {a[23:0], 8'h00} ^ 32'h5A5A0013;
    endfunction

    assign mem_dado = mem_word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic d, input logic [31:0] alvo,
                         input logic pr);
        mem_ack     = ack;
        desvio      = d;
        desvio_alvo = alvo;
        id_pronto   = pr;
    endtask

    // Holds reset for two cycles, checks the reset state, releases on a falling edge.
    task automatic do_reset(input logic [31:0] pc0);
        pc_rst = pc0;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_if_valido", {31'd0, if_valido}, 32'd0);
        chk("rst_if_instrucao", if_instrucao, NOP);
        chk("rst_if_pc", if_pc, 32'd0);
        reset = 1'b1;
    endtask

    typedef struct {
        logic        ack;
        logic        desv;
        logic [31:0] alvo;
        logic        pronto;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
        logic        valido;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic [31:0] prox;
    } vec_t;

    function automatic vec_t mk(input logic ack, input logic desv, input logic [31:0] alvo,
                                input logic pronto, input logic req, input logic chk_addr,
                                input logic [31:0] addr, input logic valido,
                                input logic [31:0] instr, input logic [31:0] ifpc,
                                input logic [31:0] prox);
        vec_t v;
        v.ack = ack; v.desv = desv; v.alvo = alvo; v.pronto = pronto;
        v.req = req; v.chk_addr = chk_addr; v.addr = addr; v.valido = valido;
        v.instr = instr; v.ifpc = ifpc; v.prox = prox;
        return v;
    endfunction

    vec_t        tbl[24];
    logic [63:0] sb[$];
    logic [63:0] front;
    logic        stale;
    logic        prev_pend;
    logic [31:0] prev_addr;
    int unsigned wait_cnt;
    logic [31:0] tmp;

    initial begin
        // ack desv alvo pronto | req chk_addr addr valido instr ifpc prox
        tbl[0]  = mk(1, 0, 0, 0,        1, 1, 0,     0, NOP,             0,     4);
        tbl[1]  = mk(0, 0, 0, 0,        0, 0, 0,     1, mem_word(0),     0,     4);
        tbl[2]  = mk(0, 0, 0, 1,        0, 0, 0,     1, mem_word(0),     0,     4);
        tbl[3]  = mk(0, 0, 0, 0,        1, 1, 4,     0, mem_word(0),     0,     4);
        tbl[4]  = mk(0, 0, 0, 0,        1, 1, 4,     0, mem_word(0),     0,     4);
        tbl[5]  = mk(1, 0, 0, 0,        1, 1, 4,     0, mem_word(0),     0,     8);
        tbl[6]  = mk(0, 0, 0, 1,        0, 0, 0,     1, mem_word(4),     4,     8);
        tbl[7]  = mk(0, 0, 0, 0,        1, 1, 8,     0, mem_word(4),     4,     8);
        tbl[8]  = mk(0, 0, 0, 0,        1, 1, 8,     0, mem_word(4),     4,     8);
        tbl[9]  = mk(0, 0, 0, 0,        1, 1, 8,     0, mem_word(4),     4,     8);
        tbl[10] = mk(1, 0, 0, 0,        1, 1, 8,     0, mem_word(4),     4,     12);
        tbl[11] = mk(0, 0, 0, 0,        0, 0, 0,     1, mem_word(8),     8,     12);
        tbl[12] = mk(0, 0, 0, 1,        0, 0, 0,     1, mem_word(8),     8,     12);
        tbl[13] = mk(0, 1, 32'h40, 0,   1, 1, 12,    0, mem_word(8),     8,     32'h40);
        tbl[14] = mk(0, 0, 0, 0,        1, 1, 12,    0, mem_word(8),     8,     32'h40);
        tbl[15] = mk(1, 0, 0, 0,        1, 1, 12,    0, mem_word(8),     8,     32'h40);
        tbl[16] = mk(1, 0, 0, 0,        1, 1, 32'h40, 0, mem_word(8),    8,     32'h44);
        tbl[17] = mk(0, 1, 32'h80, 1,   0, 0, 0,     1, mem_word(32'h40), 32'h40, 32'h80);
        tbl[18] = mk(1, 1, 32'h100, 0,  1, 1, 32'h80, 0, NOP,            32'h40, 32'h100);
        tbl[19] = mk(0, 1, 32'h200, 0,  1, 1, 32'h100, 0, NOP,           32'h40, 32'h200);
        tbl[20] = mk(0, 1, 32'h300, 0,  1, 1, 32'h100, 0, NOP,           32'h40, 32'h300);
        tbl[21] = mk(1, 0, 0, 0,        1, 1, 32'h100, 0, NOP,           32'h40, 32'h300);
        tbl[22] = mk(1, 0, 0, 0,        1, 1, 32'h300, 0, NOP,           32'h40, 32'h304);
        tbl[23] = mk(0, 0, 0, 1,        0, 0, 0,     1, mem_word(32'h300), 32'h300, 32'h304);

        reset = 1'b0;
        do_reset(32'd0);

        // Table: inputs applied on the falling edge, outputs compared 1 time unit later.
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].ack, tbl[i].desv, tbl[i].alvo, tbl[i].pronto);
            #1;
            chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, tbl[i].req});
            if (tbl[i].chk_addr) chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("v%0d_if_valido", i), {31'd0, if_valido}, {31'd0, tbl[i].valido});
            chk($sformatf("v%0d_if_instrucao", i), if_instrucao, tbl[i].instr);
            chk($sformatf("v%0d_if_pc", i), if_pc, tbl[i].ifpc);
            chk($sformatf("v%0d_if_pc4", i), if_pc4, tbl[i].ifpc + 32'd4);
            chk($sformatf("v%0d_prox", i), prox_instrucao, tbl[i].prox);
            @(negedge clock);
        end

        // Reset in the middle of a discarded request.
        drive(1'b0, 1'b1, 32'h500, 1'b0);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("midrst_pending_req", {31'd0, mem_req}, 32'd1);
        chk("midrst_pending_addr", mem_addr, 32'h304);
        pc_rst = 32'h20;
        reset  = 1'b0;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_if_valido", {31'd0, if_valido}, 32'd0);
        chk("midrst_if_instrucao", if_instrucao, NOP);
        chk("midrst_if_pc", if_pc, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_after_req", {31'd0, mem_req}, 32'd1);
        chk("midrst_after_addr", mem_addr, 32'h20);

        // PC wrap-around at the top of the address space.
        do_reset(32'hFFFFFFFC);
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        chk("wrap_addr", mem_addr, 32'hFFFFFFFC);
        chk("wrap_prox", prox_instrucao, 32'd0);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("wrap_if_valido", {31'd0, if_valido}, 32'd1);
        chk("wrap_if_pc", if_pc, 32'hFFFFFFFC);
        chk("wrap_if_pc4", if_pc4, 32'd0);
        chk("wrap_if_instrucao", if_instrucao, mem_word(32'hFFFFFFFC));
        chk("wrap_pc", estado_pc, 32'd0);

        // Randomised traffic against a scoreboard of accepted fetches.
        do_reset(32'd0);
        sb.delete();
        stale     = 1'b0;
        prev_pend = 1'b0;
        prev_addr = 32'd0;
        wait_cnt  = 0;
        for (int c = 0; c < 1500; c++) begin
            if (prev_pend) begin
                chk("rnd_req_stable", {31'd0, mem_req}, 32'd1);
                chk("rnd_addr_stable", mem_addr, prev_addr);
            end
            if (if_valido) begin
                chk("rnd_req_while_valid", {31'd0, mem_req}, 32'd0);
                chk("rnd_if_pc4", if_pc4, if_pc + 32'd4);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_unexpected_valid: got pc %h expected no instruction", if_pc);
                end else begin
                    front = sb[0];
                    chk("rnd_if_instrucao", if_instrucao, front[63:32]);
                    chk("rnd_if_pc", if_pc, front[31:0]);
                end
            end

            // Memory answers after 0..3 wait cycles; ack noise while idle must be ignored.
            if (mem_req) begin
                if (wait_cnt == 0) begin
                    mem_ack  = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt = wait_cnt - 1;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            desvio      = ($urandom_range(0, 7) == 0);
            tmp         = $urandom;
            desvio_alvo = tmp & 32'hFFFFFFFC;
            id_pronto   = 1'($urandom_range(0, 1));
            #1;

            if (mem_req && mem_ack) begin
                if (!desvio && !stale) sb.push_back({mem_dado, mem_addr});
                stale = 1'b0;
            end else if (mem_req && desvio) begin
                stale = 1'b1;
            end
            if (if_valido && (desvio || id_pronto) && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            prev_pend = mem_req && !mem_ack;
            prev_addr = mem_addr;
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
